control_sequencer: RTL

- Hardwired control unit that drives every control line of the CPU datapath bus.
- Each cycle it decodes the instruction register and issues one T-state's worth of register-transfer strobes (out-enables, in-enables, the Gra/Grb/Grc/Rin/Rout select-logic lines, ALU operation, memory strobes).
- It is the issuing end of the datapath's control interface: it fetches, decodes and executes one instruction at a time, then returns to fetch.

---
 rtl/control_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer for the single-bus CPU datapath.
// Build option: define CTRL_ILLEGAL_HALT_EN to halt on undefined opcodes instead of treating them as nop.
module control_sequencer #(
    parameter int unsigned ALU_W = 12
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      IR,
    input  logic             CON,
    input  logic             Stop,
    output logic             PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout,
    output logic             MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, R15in, r15write,
    output logic             Gra, Grb, Grc, Rin, Rout, BAout,
    output logic             IncPC, RAMread, RAMwrite, MDRRead, con_FF_Reset,
    output logic [ALU_W-1:0] ALUControl,
    output logic             Run
);
    localparam int unsigned ALU_IDX_W = 4;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR, C_JR, C_JAL,
        C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t                r_state, w_next, w_succ;
    cls_t                  w_cls;
    logic [4:0]            w_opc;
    logic [ALU_IDX_W-1:0]  w_op_alu, w_alu_idx;
    logic                  w_alu_en, w_last, w_to_halt;
    logic                  w_unused_ir;

    assign w_opc       = IR[31:27];
    assign w_unused_ir = ^IR[26:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= S_RESET;
        else      r_state <= w_next;
    end

    // Opcode -> instruction class and the one-hot index of its ALU operation (ADD by default).
    always_comb begin
        w_cls    = C_ILL;
        w_op_alu = 4'd0;
        case (w_opc)
            5'd0:  w_cls = C_LD;
            5'd1:  w_cls = C_LDI;
            5'd2:  w_cls = C_ST;
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                w_cls    = C_ALU;
                w_op_alu = 4'(w_opc - 5'd3);
            end
            5'd11: w_cls = C_IMM;
            5'd12: begin w_cls = C_IMM; w_op_alu = 4'd2; end
            5'd13: begin w_cls = C_IMM; w_op_alu = 4'd3; end
            5'd14, 5'd15: begin w_cls = C_MULDIV; w_op_alu = 4'd8 + {3'b000, w_opc[0]}; end
            5'd16, 5'd17: begin w_cls = C_NEGNOT; w_op_alu = 4'd10 + {3'b000, w_opc[0]}; end
            5'd18: w_cls = C_BR;
            5'd19: w_cls = C_JR;
            5'd20: w_cls = C_JAL;
            5'd21: w_cls = C_IN;
            5'd22: w_cls = C_OUT;
            5'd23: w_cls = C_MFHI;
            5'd24: w_cls = C_MFLO;
            5'd25: w_cls = C_NOP;
            5'd26: w_cls = C_HALT;
            default: w_cls = C_ILL;
        endcase
    end

    // Per-state strobe decode plus next-state selection.
    always_comb begin
        {PCout, MDRout, Zlowout, Zhighout, HIout, LOout, InPortout, Cout} = 8'd0;
        {MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn, R15in, r15write} = 12'd0;
        {Gra, Grb, Grc, Rin, Rout, BAout} = 6'd0;
        {IncPC, RAMread, RAMwrite, MDRRead, con_FF_Reset} = 5'd0;
        w_alu_en  = 1'b0;
        w_alu_idx = 4'd0;
        w_last    = 1'b0;
        w_to_halt = 1'b0;
        case (r_state)
            S_RESET: w_last = 1'b1;
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; w_alu_en = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; con_FF_Reset = 1'b1; end
            S_T3: begin
                case (w_cls)
                    C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_NEGNOT: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        w_alu_en = 1'b1; w_alu_idx = w_op_alu;
                    end
                    C_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    C_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; w_last = 1'b1; end
                    C_JAL:  begin PCout = 1'b1; R15in = 1'b1; r15write = 1'b1; end
                    C_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
                    C_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; w_last = 1'b1; end
                    C_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
                    C_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
                    C_NOP:  w_last = 1'b1;
                    C_HALT: w_to_halt = 1'b1;
                    default: begin
`ifdef CTRL_ILLEGAL_HALT_EN
                        w_to_halt = 1'b1;
`else
                        w_last = 1'b1;
`endif
                    end
                endcase
            end
            S_T4: begin
                case (w_cls)
                    C_ALU:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_en = 1'b1; w_alu_idx = w_op_alu; end
                    C_IMM, C_LD, C_LDI, C_ST:
                              begin Cout = 1'b1; Zin = 1'b1; w_alu_en = 1'b1; w_alu_idx = w_op_alu; end
                    C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; w_alu_en = 1'b1; w_alu_idx = w_op_alu; end
                    C_NEGNOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
                    C_BR:     begin PCout = 1'b1; Yin = 1'b1; end
                    C_JAL:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; w_last = 1'b1; end
                    default:  w_last = 1'b1;
                endcase
            end
            S_T5: begin
                case (w_cls)
                    C_ALU, C_IMM, C_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; w_last = 1'b1; end
                    C_LD, C_ST:          begin Zlowout = 1'b1; MARin = 1'b1; end
                    C_MULDIV:            begin Zlowout = 1'b1; LOin = 1'b1; end
                    C_BR:                begin Cout = 1'b1; Zin = 1'b1; w_alu_en = 1'b1; end
                    default:             w_last = 1'b1;
                endcase
            end
            S_T6: begin
                case (w_cls)
                    C_LD:     begin RAMread = 1'b1; MDRRead = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; w_last = 1'b1; end
                    C_BR: begin
                        if (CON) begin Zlowout = 1'b1; PCin = 1'b1; end
                        w_last = 1'b1;
                    end
                    default:  w_last = 1'b1;
                endcase
            end
            S_T7: begin
                if (w_cls == C_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (w_cls == C_ST) RAMwrite = 1'b1;
                w_last = 1'b1;
            end
            default: w_to_halt = 1'b1;
        endcase

        ALUControl = w_alu_en ? (ALU_W'(1) << w_alu_idx) : '0;

        case (r_state)
            S_T0:    w_succ = S_T1;
            S_T1:    w_succ = S_T2;
            S_T2:    w_succ = S_T3;
            S_T3:    w_succ = S_T4;
            S_T4:    w_succ = S_T5;
            S_T5:    w_succ = S_T6;
            S_T6:    w_succ = S_T7;
            default: w_succ = S_HALT;
        endcase

        // Stop is only honoured where the sequencer would otherwise re-enter fetch.
        if (w_to_halt)   w_next = S_HALT;
        else if (w_last) w_next = Stop ? S_HALT : S_T0;
        else             w_next = w_succ;

        Run = (r_state != S_RESET) && (r_state != S_HALT);
    end
endmodule
